gcd: RTL and testbench
======================

// Module: gcd
//
// PURPOSE
//   Iterative greatest-common-divisor engine for two unsigned W-bit operands.
//   It uses a start/valid handshake: a start pulse loads the operands, and a
//   multi-cycle subtract/swap Euclid loop runs. The result is presented with a
//   valid flag that stays asserted until the next job is accepted.
//   Standalone arithmetic helper, used by a controlling FSM or bus wrapper.
//
// PARAMETERS
//   W   10   operand and result width in bits (unsigned); W >= 2
//
// PORTS
//   clk           in   1   single clock; all state updates on its rising edge
//   rst           in   1   asynchronous, active-low reset
//   start         in   1   request; sampled only in IDLE
//   A_in          in   W   operand A, sampled in the cycle start is accepted
//   B_in          in   W   operand B, sampled in the cycle start is accepted
//   result        out  W   GCD(A,B); meaningful while result_valid=1
//   result_valid  out  1   high when result holds a completed GCD
//
// BEHAVIOUR
//   - Reset (rst=0, asynchronous): state=IDLE, a=0, b=0, result=0,
//     result_valid=0. Reset mid-computation aborts the job; no result is produced.
//   - Internal regs: a, b (W bits each). FSM states: IDLE, BUSY.
//   - IDLE, start=1: a<=A_in, b<=B_in, result_valid<=0, go to BUSY.
//     IDLE, start=0: hold all outputs.
//   - BUSY, one action per clock, in priority order:
//       b==0      : result<=a, result_valid<=1, go to IDLE
//       a<b       : swap a and b
//       otherwise : a<=a-b   (no underflow because a>=b)
//   - start is ignored in BUSY. Operand changes during BUSY have no effect.
//   - If start is still high when the FSM returns to IDLE, a new job is accepted
//     on the next edge. This clears result_valid for the re-run; the same
//     operands give the same answer.
//   - result and result_valid are registered and change only as listed above.
//     result_valid stays high in IDLE until the next job is accepted.
//   - Edge cases:
//       GCD(x,0) = x
//       GCD(0,y) = y  (swap, then done)
//       GCD(0,0) = 0
//       GCD(x,x) = x
//   - Latency: start accepted at edge 0; result_valid rises (swaps + subtracts
//     + 1) edges later. Minimum is 1 cycle (B=0). Worst case is about 2^W cycles
//     (e.g. A=2^W-1, B=1).
//   - Purely unsigned W-bit arithmetic; no overflow is possible.
//
// TESTING
//   Clock period 20 ns.
//   1. Hold rst=0 for 2 cycles -> result=0, result_valid=0.
//      Release rst, then hold start=0 for 10 cycles -> outputs unchanged.
//   2. A=752, B=168, start high for 3 cycles -> result_valid=1, result=8.
//      Both stay stable until the next start.
//   3. Then A=33, B=777, start pulse -> result_valid drops on accept,
//      then rises with result=3.
//   4. Edge operands:
//        (0,0)  -> 0
//        (45,0) -> 45
//        (0,45) -> 45
//        (17,17)-> 17
//        (1023,1) -> 1, taking about 1023 cycles.
//   5. Start a job with A=1000, B=3, assert rst=0 mid-BUSY -> outputs zero
//      immediately. After release, start A=12, B=18 -> 6.
//   6. Toggle start and change A_in/B_in while BUSY -> no effect;
//      the original job completes with the correct GCD.
//   Self-check every result against a software GCD reference model.

Source files
------------

// File: rtl/gcd.sv
// Iterative subtract/swap Euclid GCD engine with a start/valid handshake.
// result_valid stays high in IDLE until the next job is accepted.
module gcd #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A_in,
    input  logic [W-1:0] B_in,
    output logic [W-1:0] result,
    output logic         result_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t       state;
    logic [W-1:0] a;
    logic [W-1:0] b;

    // NOTE: all state, including result, uses non-blocking assignments so the
    // swap below reads the pre-edge values of both a and b.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            a            <= '0;
            b            <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a            <= A_in;
                        b            <= B_in;
                        result_valid <= 1'b0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (b == '0) begin
                        result       <= a;
                        result_valid <= 1'b1;
                        state        <= IDLE;
                    end else if (a < b) begin
                        a <= b;
                        b <= a;
                    end else begin
                        a <= a - b;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd.sv
// Self-checking bench for gcd: directed vector table plus hand-written
// sequences for reset, held start, mid-job reset and busy-time disturbance.
module tb_gcd;

    localparam int W     = 10;
    localparam int LIMIT = 4096;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A_in;
    logic [W-1:0] B_in;
    logic [W-1:0] result;
    logic         result_valid;

    int tests;
    int fails;

    gcd #(.W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .A_in         (A_in),
        .B_in         (B_in),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int exp;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference Euclid: GCD and cycle count from accept edge to valid edge.
    function automatic void model(input int a_i, input int b_i, output int g, output int lat);
        int a, b, t, steps;
        a = a_i; b = b_i; steps = 0;
        while (b != 0) begin
            if (a < b) begin t = a; a = b; b = t; end
            else a = a - b;
            steps++;
        end
        g   = a;
        lat = steps + 1;
    endfunction

    task automatic wait_valid(input bit disturb, output bit seen, output int cnt);
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < LIMIT) begin
            if (disturb) begin
                @(negedge clk);
                start = 1'($urandom_range(0, 1));
                A_in  = W'($urandom);
                B_in  = W'($urandom);
            end
            @(posedge clk);
            cnt++;
            #1;
            seen = result_valid;
        end
        start = 1'b0;
    endtask

    task automatic run_job(input string name, input int a, input int b, input int exp,
                           input bit disturb);
        bit seen;
        int cnt, g, lat;
        model(a, b, g, lat);
        @(negedge clk);
        A_in  = W'(a);
        B_in  = W'(b);
        start = 1'b1;
        @(posedge clk);
        #1;
        check({name, " valid cleared on accept"}, int'(result_valid), 0);
        if (!disturb) start = 1'b0;
        wait_valid(disturb, seen, cnt);
        check({name, " completed before timeout"}, int'(seen), 1);
        if (seen) begin
            check({name, " result"}, int'(result), exp);
            check({name, " latency"}, cnt, lat);
        end
    endtask

    vec_t vecs[$];

    initial begin
        bit seen;
        int cnt;
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        start = 1'b0;
        A_in  = '0;
        B_in  = '0;

        vecs = '{
            '{33,   777, 3},
            '{0,    0,   0},
            '{45,   0,   45},
            '{0,    45,  45},
            '{17,   17,  17},
            '{1023, 1,   1},
            '{12,   18,  6},
            '{1000, 3,   1}
        };

        // 1. reset, then idle with start low
        repeat (2) @(posedge clk);
        #1;
        check("reset result", int'(result), 0);
        check("reset valid", int'(result_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle result", int'(result), 0);
        check("idle valid", int'(result_valid), 0);

        // 2. start held for three cycles; output then holds steady
        @(negedge clk);
        A_in  = W'(752);
        B_in  = W'(168);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_valid(1'b0, seen, cnt);
        check("752,168 completed", int'(seen), 1);
        check("752,168 result", int'(result), 8);
        repeat (5) @(posedge clk);
        #1;
        check("752,168 result held", int'(result), 8);
        check("752,168 valid held", int'(result_valid), 1);

        // 3-4. vector table
        foreach (vecs[i])
            run_job($sformatf("gcd(%0d,%0d)", vecs[i].a, vecs[i].b),
                    vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);

        // start still high on return to IDLE re-runs the same job
        @(negedge clk);
        A_in  = W'(45);
        B_in  = W'(0);
        start = 1'b1;
        @(posedge clk); #1;
        check("rerun first accept valid", int'(result_valid), 0);
        @(posedge clk); #1;
        check("rerun first done valid", int'(result_valid), 1);
        check("rerun first result", int'(result), 45);
        @(posedge clk); #1;
        check("rerun second accept valid", int'(result_valid), 0);
        @(posedge clk); #1;
        check("rerun second result", int'(result), 45);
        start = 1'b0;

        // 5. reset mid-job clears outputs immediately
        @(negedge clk);
        A_in  = W'(1000);
        B_in  = W'(3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid-job reset result", int'(result), 0);
        check("mid-job reset valid", int'(result_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        check("mid-job reset no late result", int'(result_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        run_job("after reset gcd(12,18)", 12, 18, 6, 1'b0);

        // 6. start and operands scrambled while busy
        run_job("disturbed gcd(1000,3)", 1000, 3, 1, 1'b1);
        run_job("disturbed gcd(752,168)", 752, 168, 8, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
